// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter
//   Shares the single on-board RGB LED between NREQ requesters. A round-robin
//   arbiter hands the LED to one requester at a time; an owner keeps it for
//   SLOT_TICKS prescaler ticks when others are waiting, otherwise for as long
//   as it keeps requesting. A free-running prescaler supplies both the slot
//   timebase and the blink phase.
//
// Ports
//   clk    : clock
//   rst    : synchronous reset, active-high
//   req    : per-requester LED request, level-sensitive
//   color  : requester i colour in bits [3i+2:3i] = {r,g,b}
//   blink  : per-requester blink enable (1 = blink, 0 = solid)
//   grant  : one-hot owner indicator, or all zero when idle
//   busy   : 1 while any grant is active
//   led_r  : red LED drive, active-high (registered)
//   led_g  : green LED drive, active-high (registered)
//   led_b  : blue LED drive, active-high (registered)

module rgb_led_arbiter #(
  parameter int NREQ       = 4,
  parameter int TICK_DIV   = 1200000,
  parameter int SLOT_TICKS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] color,
  input  logic [NREQ-1:0]   blink,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              led_r,
  output logic              led_g,
  output logic              led_b
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SLOT_TICKS + 1);
  localparam int PW = $clog2(NREQ);

  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_TICKS - 1);
  localparam logic [PW-1:0] IDX_LAST  = PW'(NREQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic            phase;
  logic [SW-1:0]   slot, slot_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   owner, owner_n;
  logic [NREQ-1:0] others;
  logic [2:0]      owner_color;
  logic            owner_blink;

  // Index increment with wrap from NREQ-1 back to 0 (NREQ need not be a power of two).
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  // First set bit of r searching start, start+1, ... modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   start);
    logic [PW-1:0] idx;
    logic [PW-1:0] pick;
    logic          found;
    idx   = start;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign tick = (cnt == CNT_LAST);

  // Free-running prescaler; only reset clears it, grants never touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Next-state logic: acquisition, release, slot counting and hand-over.
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    slot_n  = slot;
    others  = req & ~onehot(owner);
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = OWN;
          owner_n = rr_pick(req, ptr);
          slot_n  = '0;
        end
      end
      OWN: begin
        // Release wins over an expiry landing in the same cycle.
        if (!req[owner]) begin
          state_n = IDLE;
          ptr_n   = next_idx(owner);
          slot_n  = '0;
        end else if (tick) begin
          if (slot == SLOT_LAST) begin
            slot_n = '0;
            // Direct hand-over with no idle gap; a lone owner simply renews.
            if (|others) begin
              owner_n = rr_pick(others, next_idx(owner));
              ptr_n   = next_idx(owner_n);
            end
          end else begin
            slot_n = slot + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register with registered grant/busy derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      slot  <= '0;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      slot  <= slot_n;
      grant <= (state_n == OWN) ? onehot(owner_n) : '0;
      busy  <= (state_n == OWN);
    end
  end

  assign owner_color = color[3*int'(owner) +: 3];
  assign owner_blink = blink[owner];

  // LED drive registered from the current owner, so it trails grant by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      {led_r, led_g, led_b} <= 3'b000;
    end else if (state == OWN) begin
      {led_r, led_g, led_b} <= owner_color & {3{~owner_blink | phase}};
    end else begin
      {led_r, led_g, led_b} <= 3'b000;
    end
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter
//   Directed bench for rgb_led_arbiter with TICK_DIV=4, SLOT_TICKS=3, NREQ=4.
//   After each reset release, edges are numbered E1, E2, ...; prescaler ticks
//   land on E4, E8, E12, ... and the blink phase toggles on those edges.

module tb_rgb_led_arbiter;

  localparam int NREQ       = 4;
  localparam int TICK_DIV   = 4;
  localparam int SLOT_TICKS = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [3*NREQ-1:0] color;
  logic [NREQ-1:0]  blink;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic             led_r;
  logic             led_g;
  logic             led_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_led_arbiter #(
    .NREQ      (NREQ),
    .TICK_DIV  (TICK_DIV),
    .SLOT_TICKS(SLOT_TICKS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .color(color),
    .blink(blink),
    .grant(grant),
    .busy (busy),
    .led_r(led_r),
    .led_g(led_g),
    .led_b(led_b)
  );

  // Advance one clock and settle just past the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  logic [3:0] exp_g;

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    color = 12'h000;
    blink = 4'b0000;

    // Reset with all requests active: nothing granted while rst is high.
    req   = 4'b1111;
    color = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_grant", grant, 4'b0000);
      check("rst_busy", busy, 1'b0);
      check("rst_leds", {led_r, led_g, led_b}, 3'b000);
    end
    rst = 1'b0;
    check("rel_grant", grant, 4'b0000);
    check("rel_busy", busy, 1'b0);
    check("rel_leds", {led_r, led_g, led_b}, 3'b000);
    step();
    check("first_grant", grant, 4'b0001);
    check("first_busy", busy, 1'b1);
    check("first_leds", {led_r, led_g, led_b}, 3'b000);
    step();
    check("first_leds2", {led_r, led_g, led_b}, 3'b111);

    // Single solid request on requester 2, colour 101.
    req   = 4'b0000;
    color = 12'b000_101_000_000;
    blink = 4'b0000;
    do_reset(2);
    req = 4'b0100;
    step();
    check("solid_grant", grant, 4'b0100);
    check("solid_led_lag", {led_r, led_g, led_b}, 3'b000);
    step();
    check("solid_leds", {led_r, led_g, led_b}, 3'b101);
    for (int i = 0; i < 30; i++) begin
      step();
      check("solid_hold_grant", grant, 4'b0100);
      check("solid_hold_leds", {led_r, led_g, led_b}, 3'b101);
    end
    req = 4'b0000;
    step();
    check("drop_grant", grant, 4'b0000);
    check("drop_busy", busy, 1'b0);
    check("drop_leds_lag", {led_r, led_g, led_b}, 3'b101);
    step();
    check("drop_leds", {led_r, led_g, led_b}, 3'b000);

    // Blink: owner 1, green; LED follows phase, which flips on E4, E8, ...
    req   = 4'b0000;
    color = 12'b000_000_010_000;
    blink = 4'b0010;
    do_reset(2);
    req = 4'b0010;
    step();
    check("blink_grant", grant, 4'b0010);
    for (int k = 2; k <= 16; k++) begin
      step();
      check("blink_leds", {led_r, led_g, led_b}, ((((k - 1) / 4) % 2) == 1) ? 3'b010 : 3'b000);
    end

    // Rotation among 0, 1, 3 with expiries on E12, E24, E36, E48.
    req   = 4'b0000;
    blink = 4'b0000;
    do_reset(2);
    req = 4'b1011;
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k < 12)      exp_g = 4'b0001;
      else if (k < 24) exp_g = 4'b0010;
      else if (k < 36) exp_g = 4'b1000;
      else if (k < 48) exp_g = 4'b0001;
      else             exp_g = 4'b0010;
      check("rot_grant", grant, exp_g);
      check("rot_busy", busy, 1'b1);
    end

    // Release in the same cycle as the expiry tick (E12).
    req = 4'b0000;
    do_reset(2);
    req = 4'b1001;
    for (int k = 1; k <= 11; k++) begin
      step();
      check("rve_hold", grant, 4'b0001);
    end
    req = 4'b1000;
    step();
    check("rve_gap_grant", grant, 4'b0000);
    check("rve_gap_busy", busy, 1'b0);
    step();
    check("rve_next_grant", grant, 4'b1000);
    check("rve_next_busy", busy, 1'b1);

    // Mid-slot reset: owner 1 (ptr 2) with slot count 2 after E20.
    req   = 4'b0000;
    color = 12'hFFF;
    do_reset(2);
    req = 4'b0111;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("mid_pre_grant", grant, (k < 12) ? 4'b0001 : 4'b0010);
    end
    check("mid_pre_leds", {led_r, led_g, led_b}, 3'b111);
    rst = 1'b1;
    step();
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_leds", {led_r, led_g, led_b}, 3'b000);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("mid_post_grant", grant, (k < 12) ? 4'b0001 : 4'b0010);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
Name: rgb_led_arbiter

Overview:
Shares the single on-board RGB LED between NREQ independent requesters (status, error, heartbeat, debug logic). A round-robin arbiter grants the LED to one requester at a time for a bounded slot. A free-running prescaler provides both the slot timebase and the blink phase. The block sits between the requesting logic and the top-level led_r/led_g/led_b pins.

Parameters:
NREQ, 4, number of requesters; legal range 2..8.
TICK_DIV, 1200000, clk cycles per tick (0.1 s at 12 MHz); must be >= 2.
SLOT_TICKS, 20, ticks a grant is held before rotation when others are waiting; must be >= 1.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req  input  NREQ  per-requester LED request, level-sensitive
color  input  3*NREQ  requester i colour in bits [3i+2:3i] = {r,g,b}
blink  input  NREQ  1 = blink the owner's colour, 0 = solid
grant  output  NREQ  one-hot owner indicator, or all zero
busy  output  1  1 while any grant is active
led_r  output  1  red LED drive, active-high
led_g  output  1  green LED drive, active-high
led_b  output  1  blue LED drive, active-high

Behaviour:
- Reset (rst = 1 at a clk edge) forces: prescaler count 0, tick 0, phase 0, slot count 0, rr pointer 0, state IDLE, grant 0, busy 0, led_* 0. Reset has priority over all events, including mid-grant; no partial slot survives.
- Prescaler: count runs 0..TICK_DIV-1 and wraps. The internal tick is 1 for exactly the cycle with count == TICK_DIV-1. phase toggles on every tick. The prescaler is free-running and is never reset by grants.
- Round-robin select: the search starts at index ptr and picks the first i with req[i] = 1, going ptr, ptr+1, ... mod NREQ.
- FSM states: IDLE and OWN.
- IDLE:
  - grant = 0, busy = 0.
  - If any req bit is set at edge n, the selected owner is registered: state OWN, grant one-hot and busy = 1 visible after edge n. Slot count is cleared.
- OWN (owner o):
  - Release: if req[o] = 0, go to IDLE at the next edge with grant = 0 and ptr = (o+1) mod NREQ. Release has priority over expiry in the same cycle.
  - Counting: on tick with req[o] still set, slot count increments.
  - Expiry: when tick occurs and slot count == SLOT_TICKS-1:
    - If some other req[j] (j != o) is set, hand over directly to the next requester by round-robin from o+1. There is no IDLE gap. Grant switches in one edge, ptr = (new owner + 1) mod NREQ, and slot count is cleared.
    - If no other request is pending, o keeps the LED and slot count is cleared.
- LED outputs are registered. The value after edge k is computed from state at edge k:
  - IDLE: all 0.
  - OWN: {led_r, led_g, led_b} = color[o] & {3{~blink[o] | phase}}.
- Latency: req rises before edge n (IDLE) -> grant after edge n -> LEDs reflect colour after edge n+1. A colour or blink change by the owner appears one cycle later.
- Only one grant bit is ever set. grant and busy are consistent every cycle.
- Requests from non-owners never affect LED outputs.
- Width rules: prescaler counter is clog2(TICK_DIV) bits, slot counter is clog2(SLOT_TICKS+1) bits, ptr is clog2(NREQ) bits. Wrap of ptr from NREQ-1 goes to 0.

Test Plan:
Use TICK_DIV=4, SLOT_TICKS=3, NREQ=4 for all scenarios.
- Reset: assert rst 3 cycles with req=4'b1111 -> grant=0, busy=0, leds=000 throughout and on the first cycle after release. grant=4'b0001 one cycle after rst deasserts.
- Single solid request: req=4'b0100, color[2]=3'b101, blink=0 -> grant=4'b0100 after 1 edge, led rgb=101 after 2 edges. Held indefinitely with no rotation. Dropping req gives grant=0 next edge and leds=000 the edge after.
- Blink: owner 1, color=3'b010, blink[1]=1 -> led_g toggles every 4 cycles, tracking phase. led_r=led_b=0.
- Rotation: req=4'b1011 held -> grants cycle 0001 -> 0010 -> 1000 -> 0001. Each grant lasts exactly 12 cycles (3 ticks) after the first alignment, with no zero-grant cycle between owners.
- Release vs expiry: owner 0 drops req in the same cycle as expiry tick with req[3]=1 -> grant=0 for one cycle, then grant=4'b1000 (ptr=1 search finds 3).
- Mid-slot reset: assert rst during OWN with slot count 2 -> all outputs 0 next edge. After release, the grant restarts from ptr 0 with a fresh slot.
